calc_port_responder: RTL and testbench

- Cycle-accurate responder model for one calculator request port; the other end of the master-side request drive.
- Consumes the registered per-port request stream (cmd/data/tag) and produces the DUT-side response triple (out_resp/out_data/out_tag).
- Used as a stand-in DUT port and as a reference responder for the monitor/scoreboard.
- Internally: two-beat request capture FSM, 4-entry request FIFO, single multi-cycle execute engine, registered response outputs.

---
 rtl/calc_port_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_calc_port_responder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_port_responder.sv
// calc_port_responder: responder for one calculator request port.
// Captures two-beat requests (cmd/op1/tag, then op2), queues them in a small
// FIFO, executes them one at a time with a fixed per-command latency and
// presents a one-cycle registered response (resp/data/tag).
module calc_port_responder #(
  parameter int CMD_WIDTH  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADD_LAT    = 3,
  parameter int SHIFT_LAT  = 5
) (
  input  logic                  PClk,
  input  logic                  reset,
  input  logic [CMD_WIDTH-1:0]  req_cmd_in,
  input  logic [DATA_WIDTH-1:0] req_data_in,
  input  logic [1:0]            req_tag_in,
  output logic [1:0]            out_resp,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_tag,
  output logic                  err_drop
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int MAX_LAT = (ADD_LAT > SHIFT_LAT) ? ADD_LAT : SHIFT_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT + 1) : 1;

  localparam logic [CMD_WIDTH-1:0] CMD_ADD = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] CMD_SUB = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] CMD_SHL = CMD_WIDTH'(5);
  localparam logic [CMD_WIDTH-1:0] CMD_SHR = CMD_WIDTH'(6);

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;

  typedef enum logic {
    CAP_IDLE,
    CAP_OP2
  } cap_state_t;

  // Result of one request: {resp, data}. Errors always carry zero data.
  function automatic logic [DATA_WIDTH+1:0] calc_result(
    input logic [CMD_WIDTH-1:0]  cmd,
    input logic [DATA_WIDTH-1:0] op1,
    input logic [DATA_WIDTH-1:0] op2
  );
    logic [DATA_WIDTH:0] sum;
    logic [4:0]          sh;
    sum = {1'b0, op1} + {1'b0, op2};
    sh  = op2[4:0];
    case (cmd)
      CMD_ADD: begin
        if (sum[DATA_WIDTH]) calc_result = {RESP_ERR, {DATA_WIDTH{1'b0}}};
        else                 calc_result = {RESP_OK, sum[DATA_WIDTH-1:0]};
      end
      CMD_SUB: begin
        if (op2 > op1) calc_result = {RESP_ERR, {DATA_WIDTH{1'b0}}};
        else           calc_result = {RESP_OK, op1 - op2};
      end
      CMD_SHL: calc_result = {RESP_OK, op1 << sh};
      CMD_SHR: calc_result = {RESP_OK, op1 >> sh};
      default: calc_result = {RESP_ERR, {DATA_WIDTH{1'b0}}};
    endcase
  endfunction

  // Execute-counter start value: latency minus one for the given command.
  function automatic logic [CNT_W-1:0] lat_start(input logic [CMD_WIDTH-1:0] cmd);
    if (cmd == CMD_SHL || cmd == CMD_SHR) lat_start = CNT_W'(SHIFT_LAT - 1);
    else                                  lat_start = CNT_W'(ADD_LAT - 1);
  endfunction

  cap_state_t cap_state, cap_next;
  logic       cap_load;
  logic       push_req;

  logic [CMD_WIDTH-1:0]  cap_cmd_p0;
  logic [DATA_WIDTH-1:0] cap_op1_p0;
  logic [1:0]            cap_tag_p0;

  logic [CMD_WIDTH-1:0]  fifo_cmd [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_op1 [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_op2 [FIFO_DEPTH];
  logic [1:0]            fifo_tag [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        fifo_cnt;
  logic                  fifo_empty, fifo_full;
  logic                  fifo_push, fifo_pop, bypass, drop;

  logic                  vld_p1;
  logic [CNT_W-1:0]      lat_cnt_p1;
  logic                  eng_take, eng_load, eng_done;
  logic [CMD_WIDTH-1:0]  ld_cmd;
  logic [DATA_WIDTH-1:0] ld_op1, ld_op2;
  logic [1:0]            ld_tag;

  logic [CMD_WIDTH-1:0]  ex_cmd_p1;
  logic [DATA_WIDTH-1:0] ex_op1_p1, ex_op2_p1;
  logic [1:0]            ex_tag_p1;

  // Capture FSM state register.
  always_ff @(posedge PClk or negedge reset) begin
    if (!reset) cap_state <= CAP_IDLE;
    else        cap_state <= cap_next;
  end

  // Capture FSM next state: command beat in IDLE, operand-2 beat always pushes.
  always_comb begin
    cap_next = cap_state;
    cap_load = 1'b0;
    push_req = 1'b0;
    case (cap_state)
      CAP_IDLE: begin
        if (req_cmd_in != '0) begin
          cap_load = 1'b1;
          cap_next = CAP_OP2;
        end
      end
      CAP_OP2: begin
        push_req = 1'b1;
        cap_next = CAP_IDLE;
      end
      default: cap_next = CAP_IDLE;
    endcase
  end

  // ---- stage p0: command-beat capture ----
  // Command beat fields held until the operand-2 beat completes the request.
  always_ff @(posedge PClk) begin
    if (cap_load) begin
      cap_cmd_p0 <= req_cmd_in;
      cap_op1_p0 <= req_data_in;
      cap_tag_p0 <= req_tag_in;
    end
  end

  // Queue/engine handshake. When the queue is empty and the engine is ready,
  // the new request bypasses the queue so an idle port responds LAT edges
  // after the operand-2 edge. Popping frees a slot before a push when full.
  always_comb begin
    fifo_empty = (fifo_cnt == '0);
    fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
    eng_done   = vld_p1 && (lat_cnt_p1 == '0);
    eng_take   = !vld_p1 || eng_done;
    fifo_pop   = eng_take && !fifo_empty;
    bypass     = eng_take && fifo_empty && push_req;
    fifo_push  = push_req && !bypass && (!fifo_full || fifo_pop);
    drop       = push_req && !bypass && fifo_full && !fifo_pop;
    eng_load   = fifo_pop || bypass;
    if (fifo_empty) begin
      ld_cmd = cap_cmd_p0;
      ld_op1 = cap_op1_p0;
      ld_op2 = req_data_in;
      ld_tag = cap_tag_p0;
    end else begin
      ld_cmd = fifo_cmd[rd_ptr];
      ld_op1 = fifo_op1[rd_ptr];
      ld_op2 = fifo_op2[rd_ptr];
      ld_tag = fifo_tag[rd_ptr];
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge PClk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Queue storage, written with the completed request.
  always_ff @(posedge PClk) begin
    if (fifo_push) begin
      fifo_cmd[wr_ptr] <= cap_cmd_p0;
      fifo_op1[wr_ptr] <= cap_op1_p0;
      fifo_op2[wr_ptr] <= req_data_in;
      fifo_tag[wr_ptr] <= cap_tag_p0;
    end
  end

  // ---- stage p1: execute engine ----
  // Engine occupancy and latency countdown; reloads on the finishing edge.
  always_ff @(posedge PClk or negedge reset) begin
    if (!reset) begin
      vld_p1     <= 1'b0;
      lat_cnt_p1 <= '0;
    end else if (eng_load) begin
      vld_p1     <= 1'b1;
      lat_cnt_p1 <= lat_start(ld_cmd);
    end else if (eng_done) begin
      vld_p1     <= 1'b0;
    end else if (vld_p1) begin
      lat_cnt_p1 <= lat_cnt_p1 - 1'b1;
    end
  end

  // Operands of the request currently executing.
  always_ff @(posedge PClk) begin
    if (eng_load) begin
      ex_cmd_p1 <= ld_cmd;
      ex_op1_p1 <= ld_op1;
      ex_op2_p1 <= ld_op2;
      ex_tag_p1 <= ld_tag;
    end
  end

  // ---- stage p2: registered response ----
  // Response presented for exactly one cycle; zero otherwise.
  always_ff @(posedge PClk or negedge reset) begin
    if (!reset) begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
      err_drop <= 1'b0;
    end else begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
      err_drop <= drop;
      if (eng_done) begin
        {out_resp, out_data} <= calc_result(ex_cmd_p1, ex_op1_p1, ex_op2_p1);
        out_tag              <= ex_tag_p1;
      end
    end
  end

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed testbench for calc_port_responder (default parameters:
// ADD_LAT=3, SHIFT_LAT=5, FIFO_DEPTH=4). Inputs and samples change on the
// falling edge; the DUT acts on the rising edge.
module tb_calc_port_responder;
  localparam int CW = 4;
  localparam int DW = 32;

  logic          PClk = 1'b0;
  logic          reset;
  logic [CW-1:0] req_cmd_in;
  logic [DW-1:0] req_data_in;
  logic [1:0]    req_tag_in;
  logic [1:0]    out_resp;
  logic [DW-1:0] out_data;
  logic [1:0]    out_tag;
  logic          err_drop;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int idle_bad = 0;

  int            r_cyc[$];
  logic [1:0]    r_resp[$];
  logic [DW-1:0] r_data[$];
  logic [1:0]    r_tag[$];
  int            d_cyc[$];

  calc_port_responder dut (
    .PClk(PClk),
    .reset(reset),
    .req_cmd_in(req_cmd_in),
    .req_data_in(req_data_in),
    .req_tag_in(req_tag_in),
    .out_resp(out_resp),
    .out_data(out_data),
    .out_tag(out_tag),
    .err_drop(err_drop)
  );

  always #5 PClk = ~PClk;

  always @(posedge PClk) cyc <= cyc + 1;

  // Record every response cycle and drop pulse, stamped with the edge count.
  always @(negedge PClk) begin
    if (out_resp != 2'd0) begin
      r_cyc.push_back(cyc);
      r_resp.push_back(out_resp);
      r_data.push_back(out_data);
      r_tag.push_back(out_tag);
    end else if (out_data != '0 || out_tag != 2'd0) begin
      idle_bad++;
    end
    if (err_drop) d_cyc.push_back(cyc);
  end

  task automatic clear_mon();
    r_cyc.delete();
    r_resp.delete();
    r_data.delete();
    r_tag.delete();
    d_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge PClk);
      req_cmd_in  = '0;
      req_data_in = '0;
      req_tag_in  = '0;
    end
  endtask

  // Two-beat request; e0 is the edge count after the operand-2 sampling edge.
  task automatic send(input logic [CW-1:0] cmd, input logic [DW-1:0] op1,
                      input logic [DW-1:0] op2, input logic [1:0] tag,
                      input logic [CW-1:0] op2_cmd, output int e0);
    @(negedge PClk);
    req_cmd_in  = cmd;
    req_data_in = op1;
    req_tag_in  = tag;
    @(negedge PClk);
    req_cmd_in  = op2_cmd;
    req_data_in = op2;
    req_tag_in  = 2'd0;
    e0 = cyc + 1;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    req_cmd_in  = '0;
    req_data_in = '0;
    req_tag_in  = '0;
    repeat (3) @(negedge PClk);
    checks++;
    if ({out_resp, out_data, out_tag, err_drop} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got resp=%0d data=%h tag=%0d drop=%0b want all 0",
               out_resp, out_data, out_tag, err_drop);
    end
    reset = 1'b1;
    clear_mon();
    idle(4);
    checks++;
    if (r_resp.size() !== 0 || d_cyc.size() !== 0) begin
      errors++;
      $display("FAIL reset_quiet got %0d responses %0d drops want 0 0", r_resp.size(), d_cyc.size());
    end
  endtask

  task automatic test_add_basic();
    int e0;
    clear_mon();
    send(4'd1, 32'd5, 32'd7, 2'd1, 4'd0, e0);
    idle(12);
    checks++;
    if (r_resp.size() !== 1) begin
      errors++;
      $display("FAIL add_count got %0d want 1", r_resp.size());
    end else begin
      checks++;
      if (r_cyc[0] !== e0 + 3 || r_resp[0] !== 2'd1 || r_data[0] !== 32'd12 || r_tag[0] !== 2'd1) begin
        errors++;
        $display("FAIL add_resp got cyc=%0d resp=%0d data=%0d tag=%0d want cyc=%0d resp=1 data=12 tag=1",
                 r_cyc[0], r_resp[0], r_data[0], r_tag[0], e0 + 3);
      end
    end
  endtask

  task automatic test_arith();
    int e0[3];
    logic [1:0]    er[3];
    logic [DW-1:0] ed[3];
    logic [1:0]    et[3];
    clear_mon();
    send(4'd1, 32'hFFFF_FFFF, 32'd1, 2'd2, 4'd0, e0[0]);
    send(4'd2, 32'd3, 32'd5, 2'd3, 4'd0, e0[1]);
    send(4'd2, 32'd9, 32'd4, 2'd0, 4'd0, e0[2]);
    idle(15);
    er = '{2'd2, 2'd2, 2'd1};
    ed = '{32'd0, 32'd0, 32'd5};
    et = '{2'd2, 2'd3, 2'd0};
    checks++;
    if (r_resp.size() !== 3) begin
      errors++;
      $display("FAIL arith_count got %0d want 3", r_resp.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= r_resp.size()) begin
        errors++;
        $display("FAIL arith_resp%0d got none want resp=%0d data=%0d", i, er[i], ed[i]);
      end else if (r_cyc[i] !== e0[0] + 3 * (i + 1) || r_resp[i] !== er[i] ||
                   r_data[i] !== ed[i] || r_tag[i] !== et[i]) begin
        errors++;
        $display("FAIL arith_resp%0d got cyc=%0d resp=%0d data=%0d tag=%0d want cyc=%0d resp=%0d data=%0d tag=%0d",
                 i, r_cyc[i], r_resp[i], r_data[i], r_tag[i], e0[0] + 3 * (i + 1), er[i], ed[i], et[i]);
      end
    end
  endtask

  task automatic test_shift();
    int e0, e1;
    clear_mon();
    send(4'd5, 32'h1, 32'd4, 2'd1, 4'd0, e0);
    send(4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 2'd2, 4'd0, e1);
    idle(16);
    checks++;
    if (r_resp.size() !== 2) begin
      errors++;
      $display("FAIL shift_count got %0d want 2", r_resp.size());
    end else begin
      checks++;
      if (r_cyc[0] !== e0 + 5 || r_resp[0] !== 2'd1 || r_data[0] !== 32'h10 || r_tag[0] !== 2'd1) begin
        errors++;
        $display("FAIL shl_resp got cyc=%0d resp=%0d data=%h tag=%0d want cyc=%0d resp=1 data=10 tag=1",
                 r_cyc[0], r_resp[0], r_data[0], r_tag[0], e0 + 5);
      end
      checks++;
      if (r_cyc[1] !== e0 + 10 || r_resp[1] !== 2'd1 || r_data[1] !== 32'h1 || r_tag[1] !== 2'd2) begin
        errors++;
        $display("FAIL shr_resp got cyc=%0d resp=%0d data=%h tag=%0d want cyc=%0d resp=1 data=1 tag=2",
                 r_cyc[1], r_resp[1], r_data[1], r_tag[1], e0 + 10);
      end
    end
  endtask

  task automatic test_invalid_and_op2_cmd();
    int e0, e1;
    clear_mon();
    send(4'd3, 32'd1, 32'd1, 2'd1, 4'd0, e0);
    idle(8);
    checks++;
    if (r_resp.size() !== 1 || r_cyc[0] !== e0 + 3 || r_resp[0] !== 2'd2 ||
        r_data[0] !== 32'd0 || r_tag[0] !== 2'd1) begin
      errors++;
      $display("FAIL invalid_resp got n=%0d cyc=%0d resp=%0d data=%0d want n=1 cyc=%0d resp=2 data=0 tag=1",
               r_resp.size(), r_cyc[0], r_resp[0], r_data[0], e0 + 3);
    end
    clear_mon();
    send(4'd1, 32'd10, 32'd20, 2'd2, 4'd2, e1);
    idle(12);
    checks++;
    if (r_resp.size() !== 1 || r_cyc[0] !== e1 + 3 || r_resp[0] !== 2'd1 ||
        r_data[0] !== 32'd30 || r_tag[0] !== 2'd2) begin
      errors++;
      $display("FAIL op2_cmd_ignored got n=%0d cyc=%0d resp=%0d data=%0d want n=1 cyc=%0d resp=1 data=30 tag=2",
               r_resp.size(), r_cyc[0], r_resp[0], r_data[0], e1 + 3);
    end
  endtask

  // Eight shifts at 2-cycle spacing: the engine drains one per 5 cycles, so
  // the queue is full when the eighth request completes and it is dropped.
  task automatic test_fifo_full();
    int e0[8];
    clear_mon();
    for (int k = 0; k < 8; k++)
      send(4'd5, 32'h1, DW'(k), 2'(k % 4), 4'd0, e0[k]);
    idle(30);
    checks++;
    if (r_resp.size() !== 7) begin
      errors++;
      $display("FAIL full_count got %0d want 7", r_resp.size());
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (k >= r_resp.size()) begin
        errors++;
        $display("FAIL full_resp%0d got none want data=%h", k, 32'h1 << k);
      end else if (r_cyc[k] !== e0[0] + 5 * (k + 1) || r_resp[k] !== 2'd1 ||
                   r_data[k] !== (32'h1 << k) || r_tag[k] !== 2'(k % 4)) begin
        errors++;
        $display("FAIL full_resp%0d got cyc=%0d resp=%0d data=%h tag=%0d want cyc=%0d resp=1 data=%h tag=%0d",
                 k, r_cyc[k], r_resp[k], r_data[k], r_tag[k], e0[0] + 5 * (k + 1), 32'h1 << k, k % 4);
      end
    end
    checks++;
    if (d_cyc.size() !== 1 || d_cyc[0] !== e0[7]) begin
      errors++;
      $display("FAIL full_drop got n=%0d cyc=%0d want n=1 cyc=%0d", d_cyc.size(), d_cyc[0], e0[7]);
    end
  endtask

  task automatic test_reset_busy();
    int e0, ex, n;
    clear_mon();
    send(4'd5, 32'h1, 32'd1, 2'd1, 4'd0, e0);
    send(4'd5, 32'h1, 32'd2, 2'd2, 4'd0, ex);
    send(4'd5, 32'h1, 32'd3, 2'd3, 4'd0, ex);
    n = 0;
    while (cyc < e0 + 5 && n < 20) begin
      idle(1);
      n++;
    end
    checks++;
    if (out_resp !== 2'd1 || out_data !== 32'd2 || out_tag !== 2'd1) begin
      errors++;
      $display("FAIL busy_pre_reset got resp=%0d data=%0d tag=%0d want 1 2 1", out_resp, out_data, out_tag);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({out_resp, out_data, out_tag, err_drop} !== '0) begin
      errors++;
      $display("FAIL async_reset got resp=%0d data=%h tag=%0d drop=%0b want all 0",
               out_resp, out_data, out_tag, err_drop);
    end
    repeat (2) @(negedge PClk);
    reset = 1'b1;
    clear_mon();
    idle(25);
    checks++;
    if (r_resp.size() !== 0 || d_cyc.size() !== 0) begin
      errors++;
      $display("FAIL reset_flush got %0d responses %0d drops want 0 0", r_resp.size(), d_cyc.size());
    end
    send(4'd1, 32'd2, 32'd3, 2'd3, 4'd0, ex);
    idle(8);
    checks++;
    if (r_resp.size() !== 1 || r_cyc[0] !== ex + 3 || r_resp[0] !== 2'd1 ||
        r_data[0] !== 32'd5 || r_tag[0] !== 2'd3) begin
      errors++;
      $display("FAIL post_reset_add got n=%0d cyc=%0d resp=%0d data=%0d tag=%0d want n=1 cyc=%0d resp=1 data=5 tag=3",
               r_resp.size(), r_cyc[0], r_resp[0], r_data[0], r_tag[0], ex + 3);
    end
  endtask

  task automatic test_idle_clean();
    checks++;
    if (idle_bad !== 0) begin
      errors++;
      $display("FAIL idle_outputs got %0d cycles with data/tag set while resp=0 want 0", idle_bad);
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_arith();
    test_shift();
    test_invalid_and_op2_cmd();
    test_fifo_full();
    test_reset_busy();
    test_idle_clean();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
